// File: rtl/fwpayload_uart_tx.sv
// Memory-mapped 8N1 UART transmitter for the fwpayload I/O window.
// Byte FIFO, programmable baud divisor, status readback and empty interrupt.
module fwpayload_uart_tx #(
    parameter int                   FIFO_DEPTH_LOG2 = 2,
    parameter int                   DIV_WIDTH       = 16,
    parameter logic [DIV_WIDTH-1:0] DIV_RESET       = 16'd103
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sel,
    input  logic        write,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstb,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        irq
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;
    localparam int PW    = FIFO_DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t state_q, state_d;

    logic [7:0]           mem [DEPTH];
    logic [PW-1:0]        rd_ptr, wr_ptr;
    logic [CW-1:0]        count, count_d;
    logic                 overflow, overflow_d;
    logic                 irq_en, irq_en_d;
    logic [DIV_WIDTH-1:0] div, div_d;
    logic [DIV_WIDTH-1:0] bit_div, bit_div_d;
    logic [DIV_WIDTH-1:0] cnt, cnt_d;
    logic [7:0]           shift, shift_d;
    logic [2:0]           idx, idx_d;
    logic                 tx_d, irq_d;
    logic                 push, push_ok, pop;
    logic                 empty, full, busy, bit_end;
    logic                 wr_acc;
    logic                 unused_bits;

    assign wr_acc  = sel && write;
    assign push    = wr_acc && addr == 2'd0 && wstb[0];
    assign empty   = count == '0;
    assign full    = count == CW'(DEPTH);
    assign push_ok = push && !full;
    assign busy    = state_q != IDLE;
    assign bit_end = cnt == '0;

    assign unused_bits = ^{wdata[31:16], wstb[3:2]};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            irq_en   <= 1'b0;
            div      <= DIV_RESET;
            bit_div  <= DIV_RESET;
            cnt      <= '0;
            shift    <= '0;
            idx      <= '0;
            tx       <= 1'b1;
            irq      <= 1'b0;
        end else begin
            state_q  <= state_d;
            count    <= count_d;
            overflow <= overflow_d;
            irq_en   <= irq_en_d;
            div      <= div_d;
            bit_div  <= bit_div_d;
            cnt      <= cnt_d;
            shift    <= shift_d;
            idx      <= idx_d;
            tx       <= tx_d;
            irq      <= irq_d;
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Storage needs no reset: the pointers and count define validity.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata[7:0];
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = START;
                    pop     = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end && idx == 3'd7) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!empty) begin
                        state_d = START;
                        pop     = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bit timing and shifter; divisor is latched per frame at pop time.
    always_comb begin
        shift_d   = shift;
        cnt_d     = cnt;
        idx_d     = idx;
        bit_div_d = bit_div;
        if (pop) begin
            shift_d   = mem[rd_ptr];
            bit_div_d = div;
            cnt_d     = div;
            idx_d     = '0;
        end else if (busy) begin
            if (bit_end) begin
                cnt_d = bit_div;
                if (state_q == DATA) begin
                    shift_d = {1'b0, shift[7:1]};
                    idx_d   = idx + 3'd1;
                end
            end else begin
                cnt_d = cnt - DIV_WIDTH'(1);
            end
        end
    end

    always_comb begin
        count_d = count;
        if (push_ok && !pop) begin
            count_d = count + CW'(1);
        end else if (!push_ok && pop) begin
            count_d = count - CW'(1);
        end
    end

    always_comb begin
        overflow_d = overflow;
        irq_en_d   = irq_en;
        div_d      = div;
        if (push && full) begin
            overflow_d = 1'b1;
        end else if (wr_acc && addr == 2'd1 && wstb[0] && wdata[3]) begin
            overflow_d = 1'b0;
        end
        if (wr_acc && addr == 2'd2 && wstb[0]) begin
            irq_en_d = wdata[0];
        end
        if (wr_acc && addr == 2'd3) begin
            for (int i = 0; i < DIV_WIDTH; i++) begin
                if (i < 8) begin
                    if (wstb[0]) div_d[i] = wdata[i];
                end else if (i < 16) begin
                    if (wstb[1]) div_d[i] = wdata[i];
                end
            end
        end
    end

    always_comb begin
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        irq_d = irq_en_d && count_d == '0 && state_d == IDLE;
    end

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (addr)
                2'd1: begin
                    rdata[8 +: CW] = count;
                    rdata[3]       = overflow;
                    rdata[2]       = empty;
                    rdata[1]       = full;
                    rdata[0]       = busy;
                end
                2'd2:    rdata[0] = irq_en;
                2'd3:    rdata[DIV_WIDTH-1:0] = div;
                default: rdata = '0;
            endcase
        end
    end

endmodule
